// File: rtl/uart_rx_cfg_pkg.sv
// rtl/uart_rx_cfg_pkg.sv - shared types and constants for the configurable UART receiver
// Holds the receiver state enum, parity-mode constants, the per-cycle
// control-point struct passed from FSM decode to datapath, and a majority helper.
package uart_rx_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Control points decoded from FSM state each cycle
  typedef struct packed {
    logic tick;       // oversample tick from the divider
    logic vote;       // 3-sample majority of the line at this tick
    logic decide;     // a bit decision happens this cycle
    logic shift;      // data bit decision: shift vote into payload
    logic par_smp;    // parity bit decision
    logic stop_smp;   // stop bit decision
    logic last_stop;  // final stop bit decision: frame completes
  } ctrl_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// rtl/uart_rx_cfg_if.sv - received-word handshake interface
// Signals: rx_data (payload), rx_valid, rx_ready, parity_err, frame_err, overrun.
// master = receiver side, slave = consumer side.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick generator, one-cycle tick every DIV clocks
// Ports: clock, rst_n (async active-low), restart (hold counter cleared), tick (output).
module uart_baud_tick #(
  parameter int DIV = 10
) (
  input  logic clock,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (restart || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // First tick lands DIV clocks after restart is released
  assign tick = !restart && (cnt_q == CW'(DIV - 1));
endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - oversampling UART receiver with parity/stop checking and held output word
// Ports: clock, rst_n (async active-low), rx (async serial line, idle high),
// rx_if (master modport: rx_data, rx_valid, rx_ready, parity_err, frame_err, overrun).
module uart_rx_cfg
  import uart_rx_cfg_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          rx,
  uart_rx_cfg_if.master rx_if
);
  localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int TW      = $clog2(OVERSAMPLE);
  localparam int BW      = 4;

  logic [1:0]           sync_q;
  logic                 rx_s;
  logic                 rx_prev_q;
  logic                 tick;
  state_e               state_q;
  logic [TW-1:0]        tick_cnt_q;
  logic [BW-1:0]        bit_cnt_q;
  logic [1:0]           samp_q;
  logic [DATA_BITS-1:0] data_sr_q;
  logic                 par_bit_q;
  logic                 ferr_acc_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 perr_q;
  logic                 ferr_q;
  logic                 overrun_q;
  logic                 ferr_now;
  logic                 perr_now;
  ctrl_t                ctrl;

  // rx_prev_q resets low so a start edge needs the line seen high after reset
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], rx};
      rx_prev_q <= rx_s;
    end
  end
  assign rx_s = sync_q[1];

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clock   (clock),
    .rst_n   (rst_n),
    .restart (state_q == ST_IDLE),
    .tick    (tick)
  );

  // Decisions use the current sample plus the two previous ticks' samples
  always_comb begin
    ctrl      = '0;
    ctrl.tick = tick;
    ctrl.vote = maj3(samp_q[1], samp_q[0], rx_s);
    case (state_q)
      ST_START:                    ctrl.decide = tick && (tick_cnt_q == TW'(OVERSAMPLE/2 - 1));
      ST_DATA, ST_PARITY, ST_STOP: ctrl.decide = tick && (tick_cnt_q == TW'(OVERSAMPLE - 1));
      default:                     ctrl.decide = 1'b0;
    endcase
    ctrl.shift     = ctrl.decide && (state_q == ST_DATA);
    ctrl.par_smp   = ctrl.decide && (state_q == ST_PARITY);
    ctrl.stop_smp  = ctrl.decide && (state_q == ST_STOP);
    ctrl.last_stop = ctrl.stop_smp && (bit_cnt_q == BW'(STOP_BITS - 1));
  end

  assign ferr_now = ferr_acc_q | (ctrl.stop_smp & ~ctrl.vote);
  assign perr_now = (PARITY == PAR_NONE) ? 1'b0
                  : ((^{data_sr_q, par_bit_q}) != (PARITY == PAR_ODD));

  // Control FSM
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tick_cnt_q <= '0;
          bit_cnt_q  <= '0;
          if (rx_prev_q && !rx_s) state_q <= ST_START;
        end
        ST_WAIT_HIGH: begin
          if (rx_s) state_q <= ST_IDLE;
        end
        default: begin
          if (ctrl.decide) begin
            tick_cnt_q <= '0;
            case (state_q)
              ST_START: begin
                bit_cnt_q <= '0;
                state_q   <= ctrl.vote ? ST_IDLE : ST_DATA;
              end
              ST_DATA: begin
                if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
                  bit_cnt_q <= '0;
                  state_q   <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                end else begin
                  bit_cnt_q <= bit_cnt_q + BW'(1);
                end
              end
              ST_PARITY: state_q <= ST_STOP;
              ST_STOP: begin
                if (ctrl.last_stop) state_q <= ferr_now ? ST_WAIT_HIGH : ST_IDLE;
                else                bit_cnt_q <= bit_cnt_q + BW'(1);
              end
              default: state_q <= ST_IDLE;
            endcase
          end else if (tick) begin
            tick_cnt_q <= tick_cnt_q + TW'(1);
          end
        end
      endcase
    end
  end

  // Datapath: sampling, payload assembly, held output word
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      samp_q     <= '0;
      data_sr_q  <= '0;
      par_bit_q  <= 1'b0;
      ferr_acc_q <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (ctrl.tick)                   samp_q     <= {samp_q[0], rx_s};
      if (state_q == ST_START)         ferr_acc_q <= 1'b0;
      if (ctrl.shift)                  data_sr_q  <= {ctrl.vote, data_sr_q[DATA_BITS-1:1]};
      if (ctrl.par_smp)                par_bit_q  <= ctrl.vote;
      if (ctrl.stop_smp && !ctrl.vote) ferr_acc_q <= 1'b1;
      if (rx_valid_q && rx_if.rx_ready) rx_valid_q <= 1'b0;
      if (ctrl.last_stop) begin
        // A held, unaccepted word wins; the new frame is dropped
        if (!rx_valid_q || rx_if.rx_ready) begin
          rx_data_q  <= data_sr_q;
          perr_q     <= perr_now;
          ferr_q     <= ferr_now;
          rx_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end
    end
  end

  assign rx_if.rx_data    = rx_data_q;
  assign rx_if.rx_valid   = rx_valid_q;
  assign rx_if.parity_err = perr_q;
  assign rx_if.frame_err  = ferr_q;
  assign rx_if.overrun    = overrun_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - scoreboard bench for uart_rx_cfg in 8N1, 8E1 and 7N2 configurations
module tb_uart_rx_cfg;
  import uart_rx_cfg_pkg::*;

  localparam int CLK_HZ   = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int OS       = 16;
  localparam int BIT_CLKS = CLK_HZ / BAUD;

  typedef struct {
    int         inst;
    logic [8:0] data;
    logic       pe;
    logic       fe;
  } exp_t;

  logic           clock = 1'b0;
  logic           rst_n = 1'b0;
  logic [2:0]     rx_line = 3'b111;
  logic [2:0]     ready = 3'b111;
  logic [2:0][8:0] m_data;
  logic [2:0]     m_valid, m_pe, m_fe, m_ovr;

  int   checks = 0;
  int   errors = 0;
  int   ovr_seen [3] = '{0, 0, 0};
  int   ovr_exp  [3] = '{0, 0, 0};
  int   dbits    [3] = '{8, 8, 7};
  int   par_m    [3] = '{0, 2, 0};
  int   stops_n  [3] = '{1, 1, 2};
  exp_t exp_q[$];

  always #5 clock = ~clock;

  uart_rx_cfg_if #(.DATA_BITS(8)) if0 ();
  uart_rx_cfg_if #(.DATA_BITS(8)) if1 ();
  uart_rx_cfg_if #(.DATA_BITS(7)) if2 ();

  uart_rx_cfg #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    u0 (.clock(clock), .rst_n(rst_n), .rx(rx_line[0]), .rx_if(if0.master));
  uart_rx_cfg #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
    u1 (.clock(clock), .rst_n(rst_n), .rx(rx_line[1]), .rx_if(if1.master));
  uart_rx_cfg #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2))
    u2 (.clock(clock), .rst_n(rst_n), .rx(rx_line[2]), .rx_if(if2.master));

  assign if0.rx_ready = ready[0];
  assign if1.rx_ready = ready[1];
  assign if2.rx_ready = ready[2];
  assign m_data[0] = {1'b0, if0.rx_data};
  assign m_data[1] = {1'b0, if1.rx_data};
  assign m_data[2] = {2'b00, if2.rx_data};
  assign m_valid = {if2.rx_valid, if1.rx_valid, if0.rx_valid};
  assign m_pe    = {if2.parity_err, if1.parity_err, if0.parity_err};
  assign m_fe    = {if2.frame_err, if1.frame_err, if0.frame_err};
  assign m_ovr   = {if2.overrun, if1.overrun, if0.overrun};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the oldest expectation for an instance on every accepted word
  always @(negedge clock) begin
    int idx;
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        if (m_ovr[i]) ovr_seen[i]++;
        if (m_valid[i] && ready[i]) begin
          idx = -1;
          foreach (exp_q[k]) if (idx < 0 && exp_q[k].inst == i) idx = k;
          if (idx < 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word inst%0d actual=%0h expected=none", i, m_data[i]);
          end else begin
            chk($sformatf("data_inst%0d", i), 32'(m_data[i]), 32'(exp_q[idx].data));
            chk($sformatf("parity_err_inst%0d", i), 32'(m_pe[i]), 32'(exp_q[idx].pe));
            chk($sformatf("frame_err_inst%0d", i), 32'(m_fe[i]), 32'(exp_q[idx].fe));
            exp_q.delete(idx);
          end
        end
      end
    end
  end

  task automatic drive_bit(input int inst, input logic v);
    rx_line[inst] = v;
    repeat (BIT_CLKS) @(posedge clock);
  endtask

  task automatic idle(input int inst, input int nbits);
    rx_line[inst] = 1'b1;
    repeat (nbits * BIT_CLKS) @(posedge clock);
  endtask

  // Reference: payload masked to width, parity bit chosen so total ones match
  // the mode (then optionally flipped), frame error if any checked stop bit is 0.
  task automatic send_frame(input int inst, input logic [8:0] data_in, input logic flip,
                            input logic [1:0] stop_vals, input int tail_low, input bit push);
    logic [8:0] d;
    int         ones;
    logic       pbit;
    exp_t       e;
    d    = data_in & 9'((1 << dbits[inst]) - 1);
    ones = $countones(d);
    pbit = (((ones + ((par_m[inst] == 1) ? 1 : 0)) % 2) == 1) ^ flip;
    e.inst = inst;
    e.data = d;
    e.pe   = (par_m[inst] != 0) && (((ones + int'(pbit)) % 2) != ((par_m[inst] == 1) ? 1 : 0));
    e.fe   = 1'b0;
    for (int k = 0; k < stops_n[inst]; k++) if (!stop_vals[k]) e.fe = 1'b1;
    if (push) exp_q.push_back(e);
    drive_bit(inst, 1'b0);
    for (int b = 0; b < dbits[inst]; b++) drive_bit(inst, d[b]);
    if (par_m[inst] != 0) drive_bit(inst, pbit);
    for (int k = 0; k < stops_n[inst]; k++) drive_bit(inst, stop_vals[k]);
    repeat (tail_low) drive_bit(inst, 1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (5) @(posedge clock);
    #1;
    chk("reset_valid", 32'(m_valid), 32'h0);
    chk("reset_data0", 32'(m_data[0]), 32'h0);
    chk("reset_flags", 32'({m_pe, m_fe, m_ovr}), 32'h0);
    rst_n = 1'b1;
    idle(0, 2);

    // 8N1 0xA5
    send_frame(0, 9'h0A5, 1'b0, 2'b11, 0, 1'b1);
    idle(0, 1);

    // 8E1 0x07 with wrong then correct parity bit
    send_frame(1, 9'h007, 1'b1, 2'b11, 0, 1'b1);
    idle(1, 1);
    send_frame(1, 9'h007, 1'b0, 2'b11, 0, 1'b1);
    idle(1, 1);

    // 40-clock glitch rejected, then a real frame
    rx_line[0] = 1'b0;
    repeat (40) @(posedge clock);
    rx_line[0] = 1'b1;
    repeat (200) @(posedge clock);
    #1;
    chk("glitch_idle_state", 32'(u0.state_q), 32'(ST_IDLE));
    send_frame(0, 9'h03C, 1'b0, 2'b11, 0, 1'b1);
    idle(0, 1);

    // 7N2 second stop low, line held low: stays in WAIT_HIGH until high
    send_frame(2, 9'h05B, 1'b0, 2'b01, 2, 1'b1);
    #1;
    chk("break_wait_high", 32'(u2.state_q), 32'(ST_WAIT_HIGH));
    idle(2, 2);
    send_frame(2, 9'h02A, 1'b0, 2'b11, 0, 1'b1);
    idle(2, 1);

    // Overrun: 0x11 held, 0x22 dropped
    ready[0] = 1'b0;
    send_frame(0, 9'h011, 1'b0, 2'b11, 0, 1'b1);
    idle(0, 1);
    send_frame(0, 9'h022, 1'b0, 2'b11, 0, 1'b0);
    ovr_exp[0]++;
    idle(0, 1);
    #1;
    chk("overrun_held_valid", 32'(m_valid[0]), 32'h1);
    chk("overrun_held_data", 32'(m_data[0]), 32'h11);
    ready[0] = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("valid_drop_after_ready", 32'(m_valid[0]), 32'h0);

    // Reset mid-frame with a word held
    ready[0] = 1'b0;
    send_frame(0, 9'h05A, 1'b0, 2'b11, 0, 1'b0);
    idle(0, 1);
    #1;
    chk("pre_reset_data", 32'(m_data[0]), 32'h5A);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midreset_valid", 32'(m_valid[0]), 32'h0);
    chk("midreset_data", 32'(m_data[0]), 32'h0);
    chk("midreset_state", 32'(u0.state_q), 32'(ST_IDLE));
    rx_line[0] = 1'b1;
    ready[0]   = 1'b1;
    repeat (5) @(posedge clock);
    rst_n = 1'b1;
    idle(0, 2);
    send_frame(0, 9'h099, 1'b0, 2'b11, 0, 1'b1);
    idle(0, 1);

    // Randomized traffic on all three receivers concurrently
    fork
      for (int n = 0; n < 6; n++) begin
        send_frame(0, 9'($urandom), 1'b0, ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b11, 0, 1'b1);
        idle(0, 1);
      end
      for (int n = 0; n < 6; n++) begin
        send_frame(1, 9'($urandom), 1'($urandom_range(0, 1)), 2'b11, 0, 1'b1);
        idle(1, 1);
      end
      for (int n = 0; n < 5; n++) begin
        send_frame(2, 9'($urandom), 1'b0, 2'($urandom_range(0, 3)), 0, 1'b1);
        idle(2, 1);
      end
    join

    repeat (400) @(posedge clock);
    #1;
    chk("all_words_delivered", 32'(exp_q.size()), 32'h0);
    for (int i = 0; i < 3; i++)
      chk($sformatf("overrun_count_inst%0d", i), 32'(ovr_seen[i]), 32'(ovr_exp[i]));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, line bit rate.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit; even, at least 8.
REQ-004 SHALL have parameter DATA_BITS, default 8, payload width; legal range 5..9.
REQ-005 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-006 SHALL have parameter STOP_BITS, default 1, stop bits checked; legal values 1 or 2.
REQ-007 SHALL have port clock, input, 1 bit, sole clock, rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit, asynchronous, active-low reset.
REQ-009 SHALL have port rx, input, 1 bit, asynchronous serial line, idle high.
REQ-010 SHALL have port rx_data, output, DATA_BITS bits, received payload.
REQ-011 SHALL have port rx_valid, output, 1 bit, rx_data and error flags valid.
REQ-012 SHALL have port rx_ready, input, 1 bit, consumer accepts the word.
REQ-013 SHALL have port parity_err, output, 1 bit, parity mismatch on the held word; always 0 when PARITY=0.
REQ-014 SHALL have port frame_err, output, 1 bit, a stop bit sampled low on the held word.
REQ-015 SHALL have port overrun, output, 1 bit, one-cycle pulse when a completed frame is dropped.

Function
REQ-016 SHALL pass rx through a 2-flop synchroniser (flops reset to 1); all logic uses the synchronised value.
REQ-017 SHALL generate a one-cycle sample tick every DIV = CLK_HZ/(BAUD*OVERSAMPLE) clocks; the divider restarts on leaving IDLE.
REQ-018 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-019 IDLE -> START on a synchronised 1->0 transition; the tick count clears.
REQ-020 START: at tick OVERSAMPLE/2-1 (mid start bit), a majority vote of the 3 samples at ticks OVERSAMPLE/2-3..OVERSAMPLE/2-1; vote 1 -> IDLE (glitch, no output); vote 0 -> DATA.
REQ-021 Each later bit SHALL be decided by a 3-sample majority at ticks OVERSAMPLE-3..OVERSAMPLE-1 after the previous decision, i.e. at mid-bit.
REQ-022 DATA SHALL shift LSB first for DATA_BITS bits, then go to PARITY if PARITY!=0, else STOP.
REQ-023 PARITY: parity_err computed as XOR(data, parity bit) != (PARITY==1 ? 1 : 0).
REQ-024 STOP SHALL check STOP_BITS stop bits; any low stop bit sets frame_err.
REQ-025 After the last stop decision: if frame_err -> WAIT_HIGH, else -> IDLE.
REQ-026 WAIT_HIGH (break/line held low) SHALL remain until the synchronised rx is 1, then -> IDLE; no new frame starts from WAIT_HIGH.
REQ-027 A completed frame SHALL load rx_data, parity_err and frame_err and assert rx_valid in the cycle after the last stop decision.
REQ-028 rx_valid, rx_data and the flags SHALL stay stable until a cycle with rx_valid && rx_ready; rx_valid deasserts the next cycle unless a frame completes in that same cycle, in which case the new word loads and rx_valid stays 1.
REQ-029 A completed frame while rx_valid=1 and rx_ready=0 SHALL be dropped (held word unchanged) and overrun SHALL pulse 1 cycle.
REQ-030 Frames with errors SHALL still be delivered with their flags; a glitch rejection delivers nothing.

Reset
REQ-031 rst_n low SHALL asynchronously force state IDLE, all counters 0, rx_data 0, rx_valid 0, parity_err 0, frame_err 0, overrun 0, synchroniser 1; reset mid-frame discards the frame.
REQ-032 After rst_n deasserts, a frame SHALL be accepted only after rx is seen high at least once (line idle).

Structure
REQ-033 The shared package SHALL hold the state enum, the parity-mode constants (PAR_NONE/PAR_ODD/PAR_EVEN) and the control-point struct.
REQ-034 The divider/tick generator SHALL be one sub-module, uart_baud_tick, parametrised by DIV.
REQ-035 The control FSM and the datapath SHALL be separate always blocks inside uart_rx_cfg.

Verification (CLK_HZ=1_600_000, BAUD=10_000, OVERSAMPLE=16 -> DIV=10, 160 clocks/bit)
REQ-036 8N1 frame 0xA5, rx_ready=1 -> rx_valid pulses 1 cycle, rx_data=0xA5, both flags 0.
REQ-037 8E1, data 0x07, parity bit driven 0 -> rx_data=0x07, parity_err=1; parity bit 1 -> parity_err=0.
REQ-038 40-clock low pulse on idle rx -> no rx_valid, FSM back in IDLE; next 0x3C frame received correctly.
REQ-039 7N2, second stop bit low, rx held low for 3 bit times -> rx_valid with frame_err=1, no new frame until rx returns high.
REQ-040 rx_ready=0, frames 0x11 then 0x22 -> rx_data stays 0x11, overrun pulses once at the end of 0x22; then rx_ready=1 -> rx_valid drops.
REQ-041 rst_n asserted mid-DATA of 0x55 -> all outputs 0 immediately; after release, a full 0x99 frame is received correctly.
